// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with uart_rx), frame
// constants and the data-length mask helper.
package uart_pkg;

    localparam int UART_LEN_OFFSET = 6;
    localparam int UART_CE_PER_BIT = 8;
    localparam int UART_DATA_W     = 9;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP_2 = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    // Keeps only the (len + 6) data bits so parity ignores the unused upper bits.
    function automatic logic [UART_DATA_W-1:0] uart_len_mask(input logic [1:0] len);
        case (len)
            2'd0:    uart_len_mask = 9'h03F;
            2'd1:    uart_len_mask = 9'h07F;
            2'd2:    uart_len_mask = 9'h0FF;
            default: uart_len_mask = 9'h1FF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write port of the UART transmitter holding register.
// Handshake: a word transfers on a rising i_clk where wr=1 and ready=1; ready
// drops the following clock, and wr while ready=0 is ignored (no stall, no queue).
interface uart_tx_if;
    import uart_pkg::*;

    logic                   wr;
    logic [UART_DATA_W-1:0] data;
    logic                   ready;

    modport master (output wr, output data, input ready);
    modport slave  (input wr, input data, output ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts i_ce pulses while enabled and pulses o_bit_end on
// the last pulse of each bit. Shared with uart_rx.
module uart_bit_timer #(
    parameter int CE_PER_BIT = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_ce,
    output logic o_bit_end
);

    localparam int CW = (CE_PER_BIT > 1) ? $clog2(CE_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign o_bit_end = i_en && i_ce && (cnt == CW'(CE_PER_BIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt <= '0;
        end else if (i_en && i_ce) begin
            cnt <= o_bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-word holding register feeding a frame serialiser
// (start, 6..9 data bits LSB first, optional parity, 1 or 2 stop bits).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CE_PER_BIT = UART_CE_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic [1:0] i_length,
    input  logic       i_stop2,
    input  logic       i_parity,
    input  logic       i_odd,
    uart_tx_if.slave   wr_if,
    output logic       o_tx,
    output logic       o_busy,
    output logic [2:0] o_state
);

    logic [2:0]             state;
    logic                   hold_valid;
    logic [UART_DATA_W-1:0] hold_data;
    logic [UART_DATA_W-1:0] shifter;
    logic [UART_DATA_W-1:0] masked;
    logic [3:0]             bit_cnt;
    logic [1:0]             len_l;
    logic                   stop2_l;
    logic                   parity_l;
    logic                   par_bit;
    logic                   tx_r;
    logic                   bit_end;

    assign masked = hold_data & uart_len_mask(i_length);

    uart_bit_timer #(.CE_PER_BIT(CE_PER_BIT)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (state == S_IDLE),
        .i_en      (state != S_IDLE),
        .i_ce      (i_ce),
        .o_bit_end (bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            shifter    <= '0;
            bit_cnt    <= '0;
            len_l      <= '0;
            stop2_l    <= 1'b0;
            parity_l   <= 1'b0;
            par_bit    <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            if (wr_if.wr && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= wr_if.data;
            end else if (state == S_IDLE && hold_valid) begin
                hold_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // Frame config and parity are frozen here for the whole frame.
                    if (hold_valid) begin
                        state    <= S_START;
                        tx_r     <= 1'b0;
                        shifter  <= masked;
                        len_l    <= i_length;
                        stop2_l  <= i_stop2;
                        parity_l <= i_parity;
                        par_bit  <= (^masked) ^ i_odd;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_SHIFT;
                        bit_cnt <= 4'(len_l) + 4'(UART_LEN_OFFSET);
                        tx_r    <= shifter[0];
                    end
                end
                S_SHIFT: begin
                    if (bit_end) begin
                        shifter <= shifter >> 1;
                        bit_cnt <= bit_cnt - 4'd1;
                        if (bit_cnt == 4'd1) begin
                            if (parity_l) begin
                                state <= S_PARITY;
                                tx_r  <= par_bit;
                            end else begin
                                state <= stop2_l ? S_STOP_2 : S_STOP;
                                tx_r  <= 1'b1;
                            end
                        end else begin
                            tx_r <= shifter[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state <= stop2_l ? S_STOP_2 : S_STOP;
                        tx_r  <= 1'b1;
                    end
                end
                S_STOP_2: begin
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (bit_end) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    tx_r  <= 1'b1;
                end
            endcase
        end
    end

    assign wr_if.ready = !hold_valid;
    assign o_tx        = tx_r;
    assign o_busy      = (state != S_IDLE);
    assign o_state     = state;

endmodule
